raifes_gpio_irq: RTL
====================

Name: raifes_gpio_irq

Overview:
- Parametrised successor to the fixed 8-bit GPIO peripheral; WIDTH pins.
- Adds input synchronisers, atomic set/clear writes, and per-pin edge-triggered interrupts with a combined level IRQ line.
- AHB-Lite (HASTI) slave on the peripheral side of the memory arbiter (dmem request, per_* response).
- irq drives one bit of the core's ext_interrupts.

Parameters:
- WIDTH, 8, number of GPIO pins, legal 1..32.
- BASE_ADDR, 32'hC000_0100, 64-byte-aligned register window base.
- SYNC_STAGES, 2, input synchroniser depth, legal 2..3.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- gpio_d  out  WIDTH  output data (DATA_OUT register)
- gpio_en  out  WIDTH  output enables, 1 = drive
- gpio_i  in  WIDTH  asynchronous pad inputs
- irq  out  1  |(IRQ_PEND & IRQ_EN), registered
- haddr  in  32  HASTI address
- hwrite  in  1
- hsize  in  3
- hburst  in  3
- hmastlock  in  1
- hprot  in  4
- htrans  in  2
- hwdata  in  32
- hrdata  out  32
- hready  out  1
- hresp  out  1

Behaviour:
- Reset (async assert, sync release): gpio_d=0, gpio_en=0, irq=0, hrdata=0, hready=1, hresp=OKAY, all registers 0, synchroniser flops 0.
- Zero wait states; hready is always 1 and hresp is always OKAY.
- Address phase:
  - Accepted when htrans is NONSEQ or SEQ and hready=1 and haddr[31:6]==BASE_ADDR[31:6].
  - Latch the select flag, offset haddr[5:2], hwrite, and hsize.
- Data phase:
  - Writes use hwdata in the following cycle and take effect at the end of that cycle.
  - Reads: hrdata is combinational from the latched offset and is valid in that data phase; bits [31:WIDTH] read 0.
- Only word writes (hsize=3'b010) modify state. Other sizes are ignored with an OKAY response. Reads ignore hsize.
- Unselected, IDLE or BUSY transfers leave all state unchanged and drive hrdata=0.
- Register map (offset, access):
  - 0x00 DATA_OUT, rw.
  - 0x04 OUT_EN, rw.
  - 0x08 DATA_IN, ro: synchronised input.
  - 0x0C SET, wo: DATA_OUT |= wdata.
  - 0x10 CLR, wo: DATA_OUT &= ~wdata.
  - 0x14 IRQ_EN, rw.
  - 0x18 IRQ_POL, rw: 1 = rising edge, 0 = falling edge.
  - 0x1C IRQ_PEND, read / write-1-to-clear.
  - Write-only registers and unmapped offsets read 0; writes to unmapped offsets are ignored.
- Input path:
  - gpio_i passes through a SYNC_STAGES flop chain, then one previous-value flop.
  - Edge detect: rise = s & ~p, fall = ~s & p.
  - Pad change to DATA_IN read latency is SYNC_STAGES cycles.
  - Pad change to IRQ_PEND set is SYNC_STAGES+1 cycles; irq rises one cycle later.
- Pending: pend_next = (pend & ~w1c_mask) | (POL ? rise : fall). When a W1C and a new edge hit the same bit in the same cycle, the edge wins and the bit stays set.
- IRQ_PEND is set regardless of IRQ_EN; IRQ_EN only gates irq.
- An IRQ_POL change can itself produce an edge-detected pend; this is accepted behaviour and software clears it.
- Reset mid-transfer aborts the data phase; no partial write occurs.

Optional Feature:
- Macro RAIFES_GPIO_TOGGLE_EN.
- When defined: offset 0x20 TOGGLE, wo: DATA_OUT ^= wdata; reads 0.
- When undefined: 0x20 is unmapped; writes are ignored and reads return 0.

Decomposition:
- raifes_gpio_constants.vh holds the register offsets (GPIO_OFF_DATA_OUT..GPIO_OFF_TOGGLE) and GPIO_WIN_BITS=6. HASTI widths and encodings come from raifes_hasti_constants.vh.
- Sub-module raifes_sync_edge (WIDTH, SYNC_STAGES): synchroniser plus previous-value flop; outputs sync, rise, fall.

Test Plan:
- Reset, then read 0x00/0x04/0x1C -> 0; gpio_d=0, gpio_en=0, irq=0, hready=1 throughout.
- WIDTH=8: write 0x04=0xFF, 0x00=0xA5, 0x0C=0x0A, 0x10=0x81 -> gpio_d=0xA5 -> 0xAF -> 0x2E; read 0x00=0x0000002E.
- gpio_i 0x00->0x10, IRQ_POL=0x10, IRQ_EN=0x10 -> DATA_IN=0x10 after 2 clk, IRQ_PEND=0x10 after 3 clk, irq=1 after 4 clk; W1C 0x10 -> irq=0.
- Falling edge with IRQ_POL=0 on pin 3 and IRQ_EN=0 -> IRQ_PEND=0x08, irq stays 0; set IRQ_EN=0x08 -> irq=1 the next cycle.
- W1C of pin 2 issued in the same cycle as a new rising edge on pin 2 -> IRQ_PEND[2] remains 1.
- Byte write (hsize=0) to 0x00 -> no change. Macro on: write 0x20=0xFF on DATA_OUT=0x0F -> 0xF0. Macro off: DATA_OUT unchanged.

Source files
------------

// File: rtl/raifes_gpio_irq_pkg.sv
// rtl/raifes_gpio_irq_pkg.sv - register map and HASTI encodings for the GPIO/IRQ peripheral
package raifes_gpio_irq_pkg;

    localparam int GPIO_WIN_BITS = 6;

    localparam logic [GPIO_WIN_BITS-1:0] GPIO_OFF_DATA_OUT = 6'h00;
    localparam logic [GPIO_WIN_BITS-1:0] GPIO_OFF_OUT_EN   = 6'h04;
    localparam logic [GPIO_WIN_BITS-1:0] GPIO_OFF_DATA_IN  = 6'h08;
    localparam logic [GPIO_WIN_BITS-1:0] GPIO_OFF_SET      = 6'h0C;
    localparam logic [GPIO_WIN_BITS-1:0] GPIO_OFF_CLR      = 6'h10;
    localparam logic [GPIO_WIN_BITS-1:0] GPIO_OFF_IRQ_EN   = 6'h14;
    localparam logic [GPIO_WIN_BITS-1:0] GPIO_OFF_IRQ_POL  = 6'h18;
    localparam logic [GPIO_WIN_BITS-1:0] GPIO_OFF_IRQ_PEND = 6'h1C;
    localparam logic [GPIO_WIN_BITS-1:0] GPIO_OFF_TOGGLE   = 6'h20;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       HRESP_OKAY    = 1'b0;

    // Word index within the window, as latched in the address phase
    typedef enum logic [3:0] {
        REG_DATA_OUT = GPIO_OFF_DATA_OUT[5:2],
        REG_OUT_EN   = GPIO_OFF_OUT_EN[5:2],
        REG_DATA_IN  = GPIO_OFF_DATA_IN[5:2],
        REG_SET      = GPIO_OFF_SET[5:2],
        REG_CLR      = GPIO_OFF_CLR[5:2],
        REG_IRQ_EN   = GPIO_OFF_IRQ_EN[5:2],
        REG_IRQ_POL  = GPIO_OFF_IRQ_POL[5:2],
        REG_IRQ_PEND = GPIO_OFF_IRQ_PEND[5:2],
        REG_TOGGLE   = GPIO_OFF_TOGGLE[5:2]
    } gpio_reg_e;

    function automatic logic is_active_trans(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/raifes_sync_edge.sv
// rtl/raifes_sync_edge.sv - pad input synchroniser with previous-value flop and edge detect
module raifes_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/raifes_gpio_irq.sv
// rtl/raifes_gpio_irq.sv - HASTI GPIO peripheral with set/clear writes and per-pin edge interrupts
// Optional TOGGLE register at 0x20 under RAIFES_GPIO_TOGGLE_EN.
module raifes_gpio_irq
    import raifes_gpio_irq_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'hC000_0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] gpio_d,
    output logic [WIDTH-1:0] gpio_en,
    input  logic [WIDTH-1:0] gpio_i,
    output logic             irq,
    input  logic [31:0]      haddr,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic [2:0]       hburst,
    input  logic             hmastlock,
    input  logic [3:0]       hprot,
    input  logic [1:0]       htrans,
    input  logic [31:0]      hwdata,
    output logic [31:0]      hrdata,
    output logic             hready,
    output logic             hresp
);

    logic [WIDTH-1:0] data_out, out_en, irq_en, irq_pol, irq_pend;
    logic [WIDTH-1:0] data_out_next, pend_next;
    logic [WIDTH-1:0] din_sync, din_rise, din_fall;
    logic [WIDTH-1:0] wdata;
    logic             irq_q;

    logic             sel_q, write_q;
    logic [2:0]       size_q;
    gpio_reg_e        off_q;
    logic             addr_hit, wr_en;

    logic unused_bus;
    assign unused_bus = ^{hburst, hmastlock, hprot, haddr[1:0], hwdata};

    assign hready = 1'b1;
    assign hresp  = HRESP_OKAY;

    raifes_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_i),
        .sync  (din_sync),
        .rise  (din_rise),
        .fall  (din_fall)
    );

    assign addr_hit = is_active_trans(htrans) && hready &&
                      (haddr[31:GPIO_WIN_BITS] == BASE_ADDR[31:GPIO_WIN_BITS]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q   <= 1'b0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            off_q   <= REG_DATA_OUT;
        end else begin
            sel_q   <= addr_hit;
            write_q <= hwrite;
            size_q  <= hsize;
            off_q   <= gpio_reg_e'(haddr[5:2]);
        end
    end

    assign wr_en = sel_q && write_q && (size_q == HSIZE_WORD);
    assign wdata = hwdata[WIDTH-1:0];

    always_comb begin
        data_out_next = data_out;
        if (wr_en) begin
            case (off_q)
                REG_DATA_OUT: data_out_next = wdata;
                REG_SET:      data_out_next = data_out | wdata;
                REG_CLR:      data_out_next = data_out & ~wdata;
`ifdef RAIFES_GPIO_TOGGLE_EN
                REG_TOGGLE:   data_out_next = data_out ^ wdata;
`endif
                default:      data_out_next = data_out;
            endcase
        end
    end

    // A fresh edge in the same cycle as a W1C keeps the bit set
    always_comb begin
        pend_next = irq_pend | ((irq_pol & din_rise) | (~irq_pol & din_fall));
        if (wr_en && off_q == REG_IRQ_PEND) begin
            pend_next = (irq_pend & ~wdata) |
                        ((irq_pol & din_rise) | (~irq_pol & din_fall));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            out_en   <= '0;
            irq_en   <= '0;
            irq_pol  <= '0;
            irq_pend <= '0;
            irq_q    <= 1'b0;
        end else begin
            data_out <= data_out_next;
            irq_pend <= pend_next;
            irq_q    <= |(irq_pend & irq_en);
            if (wr_en && off_q == REG_OUT_EN)  out_en  <= wdata;
            if (wr_en && off_q == REG_IRQ_EN)  irq_en  <= wdata;
            if (wr_en && off_q == REG_IRQ_POL) irq_pol <= wdata;
        end
    end

    always_comb begin
        hrdata = '0;
        if (sel_q && !write_q) begin
            case (off_q)
                REG_DATA_OUT: hrdata[WIDTH-1:0] = data_out;
                REG_OUT_EN:   hrdata[WIDTH-1:0] = out_en;
                REG_DATA_IN:  hrdata[WIDTH-1:0] = din_sync;
                REG_IRQ_EN:   hrdata[WIDTH-1:0] = irq_en;
                REG_IRQ_POL:  hrdata[WIDTH-1:0] = irq_pol;
                REG_IRQ_PEND: hrdata[WIDTH-1:0] = irq_pend;
                default:      hrdata = '0;
            endcase
        end
    end

    assign gpio_d  = data_out;
    assign gpio_en = out_en;
    assign irq     = irq_q;

endmodule
